// File: rtl/axi_ifetch_rd_slave_pkg.sv
// Shared constants, FSM encoding and word-range helper for the instruction-fetch read slave.
package axi_ifetch_rd_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA
    } state_t;

    // True when a byte address maps onto a word of a memory of depth words starting at base.
    function automatic logic word_in_range(input logic [63:0] addr,
                                           input logic [63:0] base,
                                           input logic [63:0] depth);
        logic [63:0] off;
        off = addr - base;
        return (addr >= base) && ((off >> 3) < depth);
    endfunction

endpackage

// File: rtl/axi_rd_addr_gen.sv
// Beat address stepping (INCR/FIXED) plus range and burst-legality flags for the current beat.
// Purely combinational; no latency, no backpressure.
module axi_rd_addr_gen
    import axi_ifetch_rd_slave_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(64'h8000_0000),
    parameter int                MEM_DEPTH = 4096
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2:0]        size_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              in_range_o,
    output logic              legal_o
);

    // INCR deliberately wraps modulo 2^ADDR_W; running off the memory top is flagged by in_range_o.
    assign next_addr_o = (burst_i == BURST_INCR) ? addr_i + (ADDR_W'(1) << size_i) : addr_i;
    assign in_range_o  = word_in_range(64'(addr_i), 64'(BASE_ADDR), 64'(MEM_DEPTH));
    assign legal_o     = ((burst_i == BURST_FIXED) || (burst_i == BURST_INCR)) && (size_i <= 3'd3);

endmodule

// File: rtl/axi_ifetch_rd_slave.sv
// AXI4 read responder over a 64-bit instruction word memory; YSYX_22041071_RD_PREFETCH_EN gives back-to-back beats.
// Latency: LATENCY cycles from AR handshake to first r_valid; one bubble per beat unless prefetch is built in.
// Backpressure: one transaction at a time (ar_ready only in IDLE); R outputs held while r_valid && !r_ready.
module axi_ifetch_rd_slave
    import axi_ifetch_rd_slave_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter int                DATA_W    = 64,
    parameter int                ID_W      = 4,
    parameter int                MEM_DEPTH = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(64'h8000_0000),
    parameter int                LATENCY   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ar_valid,
    output logic                         ar_ready,
    input  logic [ADDR_W-1:0]            ar_addr,
    input  logic [ID_W-1:0]              ar_id,
    input  logic [7:0]                   ar_len,
    input  logic [2:0]                   ar_size,
    input  logic [1:0]                   ar_burst,
    output logic                         r_valid,
    input  logic                         r_ready,
    output logic [DATA_W-1:0]            r_data,
    output logic [1:0]                   r_resp,
    output logic [ID_W-1:0]              r_id,
    output logic                         r_last,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
    input  logic [DATA_W-1:0]            mem_wdata
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          len_q;
    logic [7:0]          beat_cnt_q;
    logic [2:0]          size_q;
    logic [1:0]          burst_q;
    logic [3:0]          lat_cnt_q;
    logic                ar_ready_q;
    logic                r_valid_q;
    logic                r_last_q;
    logic [DATA_W-1:0]   r_data_q;
    logic [1:0]          r_resp_q;
    logic [ID_W-1:0]     r_id_q;

    logic [DATA_W-1:0]   mem [MEM_DEPTH];

    logic [ADDR_W-1:0]   next_addr;
    logic                cur_ok;
    logic                legal;
    logic [ADDR_W-1:0]   fetch_addr;
    logic                fetch_ok;
    logic [IDX_W-1:0]    fetch_idx;
    logic [DATA_W-1:0]   r_data_d;
    logic [1:0]          r_resp_d;

    axi_rd_addr_gen #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_addr_gen (
        .addr_i      (addr_q),
        .size_i      (size_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr),
        .in_range_o  (cur_ok),
        .legal_o     (legal)
    );

`ifdef YSYX_22041071_RD_PREFETCH_EN
    // While a beat is on the bus the following word is looked up so it can be loaded on acceptance.
    assign fetch_addr = (state_q == ST_DATA) ? next_addr : addr_q;
    assign fetch_ok   = (state_q == ST_DATA)
                      ? word_in_range(64'(next_addr), 64'(BASE_ADDR), 64'(MEM_DEPTH))
                      : cur_ok;
`else
    assign fetch_addr = addr_q;
    assign fetch_ok   = cur_ok;
`endif

    assign fetch_idx = IDX_W'((64'(fetch_addr) - 64'(BASE_ADDR)) >> 3);
    assign r_data_d  = (legal && fetch_ok) ? mem[fetch_idx] : '0;
    assign r_resp_d  = (legal && fetch_ok) ? RESP_OKAY : RESP_SLVERR;

    // Registered read against non-blocking backdoor write: a same-edge collision returns the old word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            lat_cnt_q  <= '0;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
            r_id_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ar_ready_q <= 1'b1;
                    if (ar_valid && ar_ready_q) begin
                        addr_q     <= ar_addr;
                        r_id_q     <= ar_id;
                        len_q      <= ar_len;
                        size_q     <= ar_size;
                        burst_q    <= ar_burst;
                        beat_cnt_q <= '0;
                        lat_cnt_q  <= 4'(LATENCY - 1);
                        ar_ready_q <= 1'b0;
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt_q == 4'd0) begin
                        r_valid_q <= 1'b1;
                        r_data_q  <= r_data_d;
                        r_resp_q  <= r_resp_d;
                        r_last_q  <= (beat_cnt_q == len_q);
                        state_q   <= ST_DATA;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end
                end
                ST_DATA: begin
                    if (r_ready) begin
                        if (beat_cnt_q == len_q) begin
                            r_valid_q  <= 1'b0;
                            r_last_q   <= 1'b0;
                            ar_ready_q <= 1'b1;
                            state_q    <= ST_IDLE;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 8'd1;
                            addr_q     <= next_addr;
`ifdef YSYX_22041071_RD_PREFETCH_EN
                            r_data_q   <= r_data_d;
                            r_resp_q   <= r_resp_d;
                            r_last_q   <= ((beat_cnt_q + 8'd1) == len_q);
`else
                            // The bubble reuses WAIT with a zero count to read the next word.
                            r_valid_q  <= 1'b0;
                            lat_cnt_q  <= '0;
                            state_q    <= ST_WAIT;
`endif
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ar_ready = ar_ready_q;
    assign r_valid  = r_valid_q;
    assign r_data   = r_data_q;
    assign r_resp   = r_resp_q;
    assign r_id     = r_id_q;
    assign r_last   = r_last_q;

endmodule

// File: tb/tb_axi_ifetch_rd_slave.sv
// Self-checking bench for axi_ifetch_rd_slave: directed vector table, stall/reset sequences, random bursts vs a reference model.
module tb_axi_ifetch_rd_slave;

    localparam int          LAT   = 1;
    localparam int          DEPTH = 4096;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam logic [63:0] M0    = 64'h0000_0013_0000_0093;
    localparam logic [63:0] MTOP  = 64'hDEAD_BEEF_0FFF_0FFF;
`ifdef YSYX_22041071_RD_PREFETCH_EN
    localparam int EXP_SPAN4 = 4;
`else
    localparam int EXP_SPAN4 = 7;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ar_valid = 1'b0;
    logic        ar_ready;
    logic [63:0] ar_addr = '0;
    logic [3:0]  ar_id = '0;
    logic [7:0]  ar_len = '0;
    logic [2:0]  ar_size = '0;
    logic [1:0]  ar_burst = '0;
    logic        r_valid;
    logic        r_ready = 1'b0;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic [3:0]  r_id;
    logic        r_last;
    logic        mem_we = 1'b0;
    logic [11:0] mem_waddr = '0;
    logic [63:0] mem_wdata = '0;

    axi_ifetch_rd_slave #(
        .ADDR_W(64), .DATA_W(64), .ID_W(4), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .r_id(r_id), .r_last(r_last),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_chk = 0;
    int n_pass = 0;
    logic [63:0] model_mem [DEPTH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Expected {resp, data} for beat k, straight from the address/burst/range rules.
    function automatic logic [65:0] model_beat(input logic [63:0] addr, input logic [2:0] size,
                                               input logic [1:0] burst, input int k);
        logic [63:0] a;
        bit ok;
        a  = (burst == 2'b01) ? addr + (64'(k) << size) : addr;
        ok = (burst == 2'b00 || burst == 2'b01) && (size <= 3) && (a >= BASE) && ((a - BASE) / 8 < DEPTH);
        if (ok) return {2'b00, model_mem[int'((a - BASE) / 8)]};
        return {2'b10, 64'd0};
    endfunction

    // mode 0: r_ready always 1; mode 1: r_ready 0,0,1 per beat; mode 2: random r_ready.
    task automatic run_burst(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [3:0] id, input int mode,
                             output logic [63:0] d_first, output logic [1:0] rs_first,
                             output logic [63:0] d_last, output logic [1:0] rs_last,
                             output int lat, output int span);
        int guard, beats, ph, ar_cyc, first_cyc, last_cyc;
        bit got_first, held, rdy;
        logic [63:0] hd;
        logic [6:0]  hm;
        logic [65:0] e;
        d_first = '0; rs_first = '0; d_last = '0; rs_last = '0; lat = -1; span = -1;
        @(negedge clk);
        ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_id = id; ar_valid = 1'b1;
        guard = 0;
        while (ar_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (ar_ready !== 1'b1) begin
            chk("ar_accept", 64'(ar_ready), 64'd1);
            ar_valid = 1'b0;
            return;
        end
        ar_cyc = cyc + 1;
        @(negedge clk);
        ar_valid = 1'b0;
        beats = 0; guard = 0; ph = 0; held = 0; got_first = 0; first_cyc = 0; last_cyc = 0;
        while (beats <= int'(len) && guard < 400) begin
            if (held) begin
                chk("hold_valid", 64'(r_valid), 64'd1);
                chk("hold_data", r_data, hd);
                chk("hold_meta", 64'({r_resp, r_id, r_last}), 64'(hm));
                held = 0;
            end
            if (r_valid && !got_first) begin
                got_first = 1;
                first_cyc = cyc;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (ph == 2);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            r_ready = rdy;
            if (r_valid && rdy) begin
                e = model_beat(addr, size, burst, beats);
                chk("beat_data", r_data, e[63:0]);
                chk("beat_resp", 64'(r_resp), 64'(e[65:64]));
                chk("beat_id", 64'(r_id), 64'(id));
                chk("beat_last", 64'(r_last), 64'(beats == int'(len)));
                if (beats == 0) begin d_first = r_data; rs_first = r_resp; end
                d_last = r_data; rs_last = r_resp;
                last_cyc = cyc;
                beats++;
                ph = 0;
            end else if (r_valid) begin
                held = 1;
                hd = r_data;
                hm = {r_resp, r_id, r_last};
                ph++;
            end
            @(negedge clk);
            guard++;
        end
        r_ready = 1'b0;
        chk("beats_received", 64'(beats), 64'(int'(len) + 1));
        chk("idle_ar_ready", 64'(ar_ready), 64'd1);
        chk("idle_r_valid", 64'(r_valid), 64'd0);
        lat  = first_cyc - ar_cyc;
        span = last_cyc - first_cyc + 1;
    endtask

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  id;
        logic [63:0] e_dfirst;
        logic [1:0]  e_rfirst;
        logic [63:0] e_dlast;
        logic [1:0]  e_rlast;
    } vec_t;

    initial begin
        vec_t        vt [10];
        logic [63:0] df, dl, v, a;
        logic [1:0]  rf, rl;
        int          lat, span, guard, beats;
        logic [2:0]  sz;
        logic [1:0]  bu;

        vt[0] = '{64'h8000_0000,          8'd0, 3'd3, 2'b01, 4'd3,  M0,    2'b00, M0,    2'b00};
        vt[1] = '{64'h8000_0008,          8'd3, 3'd3, 2'b01, 4'd1,  64'd1, 2'b00, 64'd4, 2'b00};
        vt[2] = '{64'h8000_7FF8,          8'd1, 3'd3, 2'b01, 4'd5,  MTOP,  2'b00, 64'd0, 2'b10};
        vt[3] = '{64'h8000_0000,          8'd2, 3'd3, 2'b10, 4'd2,  64'd0, 2'b10, 64'd0, 2'b10};
        vt[4] = '{64'h7FFF_FFF8,          8'd0, 3'd3, 2'b01, 4'd4,  64'd0, 2'b10, 64'd0, 2'b10};
        vt[5] = '{64'h8000_0010,          8'd2, 3'd3, 2'b00, 4'd6,  64'd2, 2'b00, 64'd2, 2'b00};
        vt[6] = '{64'h8000_0008,          8'd1, 3'd3, 2'b11, 4'd7,  64'd0, 2'b10, 64'd0, 2'b10};
        vt[7] = '{64'h8000_0008,          8'd0, 3'd4, 2'b01, 4'd8,  64'd0, 2'b10, 64'd0, 2'b10};
        vt[8] = '{64'h8000_0008,          8'd3, 3'd2, 2'b01, 4'd9,  64'd1, 2'b00, 64'd2, 2'b00};
        vt[9] = '{64'hFFFF_FFFF_FFFF_FFF8, 8'd1, 3'd3, 2'b01, 4'd10, 64'd0, 2'b10, 64'd0, 2'b10};

        // Program load through the backdoor while reset is held.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (i == 0)              v = M0;
            else if (i <= 4)         v = 64'(i);
            else if (i == DEPTH - 1) v = MTOP;
            else                     v = {$urandom, $urandom};
            mem_we = 1'b1; mem_waddr = 12'(i); mem_wdata = v;
            model_mem[i] = v;
        end
        @(negedge clk);
        mem_we = 1'b0;

        chk("rst_ar_ready", 64'(ar_ready), 64'd0);
        chk("rst_r_valid", 64'(r_valid), 64'd0);
        chk("rst_r_last", 64'(r_last), 64'd0);
        chk("rst_r_resp", 64'(r_resp), 64'd0);
        chk("rst_r_id", 64'(r_id), 64'd0);
        chk("rst_r_data", r_data, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ar_ready_after_reset", 64'(ar_ready), 64'd1);

        for (int i = 0; i < 10; i++) begin
            run_burst(vt[i].addr, vt[i].len, vt[i].size, vt[i].burst, vt[i].id, 0, df, rf, dl, rl, lat, span);
            chk($sformatf("vec%0d_first_data", i), df, vt[i].e_dfirst);
            chk($sformatf("vec%0d_first_resp", i), 64'(rf), 64'(vt[i].e_rfirst));
            chk($sformatf("vec%0d_last_data", i), dl, vt[i].e_dlast);
            chk($sformatf("vec%0d_last_resp", i), 64'(rl), 64'(vt[i].e_rlast));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
            if (i == 1) chk("len3_span", 64'(span), 64'(EXP_SPAN4));
        end

        // Stalled burst: r_ready 0,0,1 on every beat.
        run_burst(vt[1].addr, vt[1].len, vt[1].size, vt[1].burst, vt[1].id, 1, df, rf, dl, rl, lat, span);
        chk("stall_first_data", df, 64'd1);
        chk("stall_last_data", dl, 64'd4);

        // Reset while beat 2 of a len=7 burst is on the bus.
        @(negedge clk);
        ar_addr = BASE; ar_len = 8'd7; ar_size = 3'd3; ar_burst = 2'b01; ar_id = 4'hC; ar_valid = 1'b1;
        guard = 0;
        while (ar_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        ar_valid = 1'b0; r_ready = 1'b1; beats = 0; guard = 0;
        while (!(r_valid === 1'b1 && beats == 1) && guard < 100) begin
            if (r_valid === 1'b1) beats++;
            @(negedge clk);
            guard++;
        end
        chk("rst_beat2_valid", 64'(r_valid), 64'd1);
        chk("rst_beat2_data", r_data, 64'd1);
        r_ready = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("midrst_r_valid", 64'(r_valid), 64'd0);
        chk("midrst_ar_ready", 64'(ar_ready), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("postrst_ar_ready", 64'(ar_ready), 64'd1);
        chk("postrst_r_valid", 64'(r_valid), 64'd0);
        run_burst(vt[0].addr, vt[0].len, vt[0].size, vt[0].burst, vt[0].id, 0, df, rf, dl, rl, lat, span);
        chk("postrst_data", df, M0);

        // Randomized bursts with random backpressure.
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0:       a = BASE + 64'($urandom_range(0, DEPTH * 8 - 1));
                1:       a = BASE + 64'(DEPTH * 8 - 64) + 64'($urandom_range(0, 63));
                2:       a = BASE - 64'($urandom_range(1, 64));
                default: a = {$urandom, $urandom};
            endcase
            sz = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            bu = ($urandom_range(0, 9) < 7) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            run_burst(a, 8'($urandom_range(0, 7)), sz, bu, 4'($urandom_range(0, 15)), 2, df, rf, dl, rl, lat, span);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
